// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions for the data-memory responder: funct3 codes,
// FSM state encoding and the captured request record.
// Imported by the interface, the lane formatter and the responder top.
package dmem_responder_pkg;

   // RISC-V load/store funct3 codes (stores use only B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Responder FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Request captured at accept. addr is kept at full 32 bits so the record
   // does not depend on the instance's address width; upper bits are unused.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
   } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the EX/MEM stage and the responder.
// master: drives req_* and receives req_ready/rsp_*; slave: the responder side.
// One request outstanding at a time; rsp_valid is a single-cycle pulse.
interface dmem_responder_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   import dmem_responder_pkg::*;

   logic                  req_valid;
   logic                  req_we;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [2:0]            req_funct3;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store merge, byte enables, load extension and access check.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the responder samples it.
// Ports: funct3/we/byte_off/old_word/wdata in; new_word/be/load_data/err out.
module dmem_lane_fmt
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        we,
   input  logic [1:0]  byte_off,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] new_word,
   output logic [3:0]  be,
   output logic [31:0] load_data,
   output logic        err
);

   logic [3:0]  lanes;
   logic        bad;
   logic [31:0] shifted;
   logic [31:0] ext;
   logic [31:0] rep;

   // Addressed byte/half moved down to bit 0 for extension
   assign shifted = old_word >> {byte_off, 3'b000};

   always_comb begin
      lanes = 4'b0000;
      bad   = 1'b0;
      ext   = '0;
      rep   = wdata;
      case (funct3)
         F3_B, F3_BU: begin
            lanes = 4'b0001 << byte_off;
            rep   = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            lanes = byte_off[1] ? 4'b1100 : 4'b0011;
            bad   = byte_off[0];
            rep   = {2{wdata[15:0]}};
         end
         F3_W: begin
            lanes = 4'b1111;
            bad   = |byte_off;
         end
         default: bad = 1'b1;
      endcase
      // Unsigned codes exist only for loads
      if (we && (funct3 == F3_BU || funct3 == F3_HU)) begin
         bad = 1'b1;
      end
      case (funct3)
         F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ext = {24'h000000, shifted[7:0]};
         F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ext = {16'h0000, shifted[15:0]};
         F3_W:    ext = old_word;
         default: ext = '0;
      endcase
   end

   assign err       = bad;
   assign be        = (we && !bad) ? lanes : 4'b0000;
   assign load_data = (we || bad) ? 32'h0000_0000 : ext;

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            new_word[8*i +: 8] = rep[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the word array, serves one load/store at a time.
// Latency: WAIT_CYCLES+1 cycles from accept to the one-cycle rsp_valid pulse.
// Backpressure: req_ready only in IDLE (and not in reset); requests held off otherwise.
// Ports: clk, reset (sync, active-high), bus (slave side of dmem_responder_if).
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int         DEPTH     = 1 << (DM_ADDRESS - 2);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state;
   logic [3:0]        wait_cnt;
   req_t              cap_q;
   req_t              live;
   req_t              cur;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   logic                  accept;
   logic                  enter_resp;
   logic [DM_ADDRESS-3:0] idx;
   logic [31:0]           fmt_word;
   logic [3:0]            fmt_be;
   logic [31:0]           fmt_load;
   logic                  fmt_err;
   logic                  unused_addr_hi;

   always_comb begin
      live                       = '0;
      live.we                    = bus.req_we;
      live.addr[DM_ADDRESS-1:0]  = bus.req_addr;
      live.wdata                 = bus.req_wdata;
      live.funct3                = bus.req_funct3;
   end

   assign accept = bus.req_valid && (state == ST_IDLE);

   // With no wait states the array is accessed on the accept edge itself,
   // so the live request feeds the formatter instead of the capture register.
   assign enter_resp = (accept && WAIT_CYCLES == 0) ||
                       (state == ST_WAIT && wait_cnt == 4'd0);
   assign cur        = (state == ST_IDLE) ? live : cap_q;
   assign idx        = cur.addr[DM_ADDRESS-1:2];
   assign unused_addr_hi = ^cur.addr[31:DM_ADDRESS];

   dmem_lane_fmt u_fmt (
      .funct3    (cur.funct3),
      .we        (cur.we),
      .byte_off  (cur.addr[1:0]),
      .old_word  (mem[idx]),
      .wdata     (cur.wdata),
      .new_word  (fmt_word),
      .be        (fmt_be),
      .load_data (fmt_load),
      .err       (fmt_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= 4'd0;
         cap_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cap_q <= live;
                  if (WAIT_CYCLES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (enter_resp) begin
            rsp_rdata_q <= fmt_load;
            rsp_err_q   <= fmt_err;
            if (|fmt_be) begin
               mem[idx] <= fmt_word;
            end
         end
      end
   end

   assign bus.req_ready = (state == ST_IDLE) && !reset;
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked
// against a byte-level reference model of the storage array.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic clk = 1'b0;
   logic rst0, rst3;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] m0 [128];
   logic [31:0] m3 [128];

   dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();
   dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus3 ();

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(rst0), .bus(bus0));
   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(rst3), .bus(bus3));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we, input logic [8:0] a,
                        input logic [31:0] d, input logic [2:0] f);
      if (sel) begin
         bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = a;
         bus3.req_wdata = d; bus3.req_funct3 = f;
      end else begin
         bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a;
         bus0.req_wdata = d; bus0.req_funct3 = f;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? bus3.req_ready : bus0.req_ready;
   endfunction
   function automatic logic vld(input bit sel);
      return sel ? bus3.rsp_valid : bus0.rsp_valid;
   endfunction
   function automatic logic [31:0] rdat(input bit sel);
      return sel ? bus3.rsp_rdata : bus0.rsp_rdata;
   endfunction
   function automatic logic rerr(input bit sel);
      return sel ? bus3.rsp_err : bus0.rsp_err;
   endfunction

   // Reference: access size / signedness from funct3, alignment by modulo,
   // byte-by-byte store into the model word.
   function automatic void model(input bit sel, input logic we, input logic [8:0] a,
                                 input logic [31:0] d, input logic [2:0] f,
                                 output logic [31:0] rd, output logic err);
      int size, off, idx;
      bit sgn, legal;
      logic [31:0] w, mask;
      case (f)
         3'd0:    begin size = 1; sgn = 1; legal = 1;   end
         3'd1:    begin size = 2; sgn = 1; legal = 1;   end
         3'd2:    begin size = 4; sgn = 0; legal = 1;   end
         3'd4:    begin size = 1; sgn = 0; legal = !we; end
         3'd5:    begin size = 2; sgn = 0; legal = !we; end
         default: begin size = 1; sgn = 0; legal = 0;   end
      endcase
      off = int'(a) % 4;
      idx = int'(a) / 4;
      err = !legal || (off % size != 0);
      rd  = 32'h0;
      if (err) return;
      w = sel ? m3[idx] : m0[idx];
      if (we) begin
         for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = d[8*k +: 8];
         if (sel) m3[idx] = w; else m0[idx] = w;
      end else begin
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
         rd = (w >> (8*off)) & mask;
         if (sgn && size < 4 && rd[8*size-1]) rd = rd | ~mask;
      end
   endfunction

   // One request: accept, latency, data, error, pulse width, ready recovery.
   task automatic do_req(input bit sel, input logic we, input logic [8:0] a,
                         input logic [31:0] d, input logic [2:0] f, input string tag,
                         output logic [31:0] obs_rd, output logic obs_err);
      int n;
      logic [31:0] exp_rd;
      logic exp_err;
      model(sel, we, a, d, f, exp_rd, exp_err);
      @(negedge clk);
      drive(sel, 1'b1, we, a, d, f);
      n = 0;
      while (!rdy(sel) && n < 40) begin @(negedge clk); n++; end
      check({tag, "/accept"}, 32'(rdy(sel)), 32'd1);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      check({tag, "/busy"}, 32'(rdy(sel)), 32'd0);
      n = 1;
      while (!vld(sel) && n < 40) begin @(negedge clk); n++; end
      check({tag, "/latency"}, n, sel ? 32'd4 : 32'd1);
      obs_rd  = rdat(sel);
      obs_err = rerr(sel);
      check({tag, "/rdata"}, obs_rd, exp_rd);
      check({tag, "/err"}, 32'(obs_err), 32'(exp_err));
      @(negedge clk);
      check({tag, "/pulse"}, 32'(vld(sel)), 32'd0);
      check({tag, "/ready_back"}, 32'(rdy(sel)), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        rh [16];
      logic        vh [16];
      int          nrsp;

      for (int i = 0; i < 128; i++) begin m0[i] = '0; m3[i] = '0; end
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      rst0 = 1'b1;
      rst3 = 1'b1;
      repeat (3) @(negedge clk);
      check("reset/ready_low0", 32'(bus0.req_ready), 32'd0);
      check("reset/ready_low3", 32'(bus3.req_ready), 32'd0);
      rst0 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      check("reset/ready", 32'(bus0.req_ready), 32'd1);
      check("reset/rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      check("reset/rsp_rdata", bus0.rsp_rdata, 32'd0);
      check("reset/rsp_err", 32'(bus0.rsp_err), 32'd0);
      check("reset/ready3", 32'(bus3.req_ready), 32'd1);

      // Aligned word round trip
      do_req(0, 1, 9'h010, 32'hDEADBEEF, F3_W, "sw010", rd, er);
      do_req(0, 0, 9'h010, 32'h0, F3_W, "lw010", rd, er);
      check("rt/lw_value", rd, 32'hDEADBEEF);
      check("rt/lw_err", 32'(er), 32'd0);

      // Sub-word sign handling
      do_req(0, 1, 9'h020, 32'h8081F0F1, F3_W, "sw020", rd, er);
      do_req(0, 0, 9'h023, 32'h0, F3_B, "lb023", rd, er);
      check("sign/lb", rd, 32'hFFFFFF80);
      do_req(0, 0, 9'h023, 32'h0, F3_BU, "lbu023", rd, er);
      check("sign/lbu", rd, 32'h00000080);
      do_req(0, 0, 9'h020, 32'h0, F3_H, "lh020", rd, er);
      check("sign/lh", rd, 32'hFFFFF0F1);
      do_req(0, 0, 9'h022, 32'h0, F3_HU, "lhu022", rd, er);
      check("sign/lhu", rd, 32'h00008081);

      // Lane-masked stores
      do_req(0, 1, 9'h030, 32'h11223344, F3_W, "sw030", rd, er);
      do_req(0, 1, 9'h031, 32'h000000AA, F3_B, "sb031", rd, er);
      do_req(0, 1, 9'h032, 32'h0000BEEF, F3_H, "sh032", rd, er);
      do_req(0, 0, 9'h030, 32'h0, F3_W, "lw030", rd, er);
      check("mask/lw", rd, 32'hBEEFAA44);

      // Error cases
      do_req(0, 0, 9'h006, 32'h0, F3_W, "lw006", rd, er);
      check("errc/lw_mis_err", 32'(er), 32'd1);
      check("errc/lw_mis_data", rd, 32'd0);
      do_req(0, 1, 9'h041, 32'h0000FFFF, F3_H, "sh041", rd, er);
      check("errc/sh_mis_err", 32'(er), 32'd1);
      do_req(0, 0, 9'h040, 32'h0, F3_W, "lw040", rd, er);
      check("errc/no_write", rd, 32'd0);
      do_req(0, 0, 9'h040, 32'h0, 3'b011, "f3_011", rd, er);
      check("errc/f3_011", 32'(er), 32'd1);

      // Random traffic, mostly in a small window so loads hit earlier stores
      for (int i = 0; i < 60; i++) begin
         logic [8:0] a;
         a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63));
         do_req(0, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                "rand0", rd, er);
      end
      for (int i = 0; i < 10; i++) begin
         do_req(1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom,
                3'($urandom_range(0, 5)), "rand3", rd, er);
      end

      // Wait states with req_valid held high: accepts every 5 cycles
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 9'h010, 32'h0, F3_W);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         rh[c] = bus3.req_ready;
         vh[c] = bus3.rsp_valid;
         if (c == 15) drive(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      end
      nrsp = 0;
      for (int c = 0; c < 15; c++) begin
         check($sformatf("hold/ready_c%0d", c), 32'(rh[c]), 32'((c % 5) == 0));
         check($sformatf("hold/valid_c%0d", c), 32'(vh[c]), 32'((c % 5) == 4));
         if (vh[c]) nrsp++;
      end
      check("hold/responses", nrsp, 32'd3);

      // Reset two cycles after a store is accepted
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 9'h050, 32'h12345678, F3_W);
      check("rst1/ready_pre", 32'(bus3.req_ready), 32'd1);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      check("rst1/ready_in_reset", 32'(bus3.req_ready), 32'd0);
      check("rst1/no_valid_a", 32'(bus3.rsp_valid), 32'd0);
      @(negedge clk);
      check("rst1/no_valid_b", 32'(bus3.rsp_valid), 32'd0);
      rst3 = 1'b0;
      for (int i = 0; i < 128; i++) m3[i] = '0;
      nrsp = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus3.rsp_valid) nrsp++;
      end
      check("rst1/no_response", nrsp, 32'd0);
      check("rst1/ready_after", 32'(bus3.req_ready), 32'd1);
      check("rst1/rdata_after", bus3.rsp_rdata, 32'd0);
      do_req(1, 0, 9'h050, 32'h0, F3_W, "rst1_lw050", rd, er);
      check("rst1/lw050", rd, 32'h00000000);

      // Reset on the very edge that would commit the store
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 9'h054, 32'hCAFEF00D, F3_W);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
      @(negedge clk);
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      check("rst2/no_valid", 32'(bus3.rsp_valid), 32'd0);
      rst3 = 1'b0;
      for (int i = 0; i < 128; i++) m3[i] = '0;
      @(negedge clk);
      check("rst2/ready_after", 32'(bus3.req_ready), 32'd1);
      check("rst2/no_valid_after", 32'(bus3.rsp_valid), 32'd0);
      do_req(1, 0, 9'h054, 32'h0, F3_W, "rst2_lw054", rd, er);
      check("rst2/lw054", rd, 32'h00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
